// File: rtl/bypass_net_if.sv
// Signal bundle between the issue/read side and the bypass network.
interface bypass_net_if #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NSTAGE = 3,
  parameter int NPORT  = 2
);
  localparam int OW = $clog2(NSTAGE + 1);

  logic                   advance;
  logic                   flush;
  logic                   issue_valid;
  logic [AW-1:0]          issue_dst;
  logic                   issue_rdy;
  logic [DW-1:0]          issue_data;
  logic                   late_valid;
  logic [DW-1:0]          late_data;
  logic [NPORT*AW-1:0]    rd_addr;
  logic [NPORT*DW-1:0]    rf_data;
  logic [NPORT*DW-1:0]    out_data;
  logic                   stall;
  logic [OW-1:0]          occ;

  modport master (
    output advance, flush, issue_valid, issue_dst, issue_rdy, issue_data,
           late_valid, late_data, rd_addr, rf_data,
    input  out_data, stall, occ
  );

  modport slave (
    input  advance, flush, issue_valid, issue_dst, issue_rdy, issue_data,
           late_valid, late_data, rd_addr, rf_data,
    output out_data, stall, occ
  );
endinterface

// File: rtl/bypass_net.sv
// Operand bypass network: tracks in-flight results and forwards the youngest
// matching producer to each read port, stalling when that producer is not ready.
module bypass_net #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NSTAGE = 3,
  parameter int NPORT  = 2,
  parameter int LRS    = 1
) (
  input logic         clk,
  input logic         rst,
  bypass_net_if.slave bus
);
  localparam int          OW        = $clog2(NSTAGE + 1);
  localparam int unsigned LATE_NEXT = LRS + 1;

  logic          r_valid [NSTAGE];
  logic [AW-1:0] r_dst   [NSTAGE];
  logic          r_rdy   [NSTAGE];
  logic [DW-1:0] r_data  [NSTAGE];

  logic                w_late_hit;
  logic [NPORT*DW-1:0] w_out;
  logic                w_stall;
  logic [OW-1:0]       w_occ;

  assign w_late_hit = r_valid[LRS] && !r_rdy[LRS] && bus.late_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        r_valid[k] <= 1'b0;
        r_dst[k]   <= '0;
        r_rdy[k]   <= 1'b0;
        r_data[k]  <= '0;
      end
    end else if (bus.flush) begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        r_valid[k] <= 1'b0;
      end
    end else if (bus.advance) begin
      r_valid[0] <= bus.issue_valid && (bus.issue_dst != '0);
      r_dst[0]   <= bus.issue_dst;
      r_rdy[0]   <= bus.issue_rdy;
      r_data[0]  <= bus.issue_data;
      // A late result arriving on a shift follows its entry into the next stage;
      // when LRS is the oldest stage it simply falls off the end.
      for (int unsigned k = 1; k < NSTAGE; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_dst[k]   <= r_dst[k-1];
        if (k == LATE_NEXT && w_late_hit) begin
          r_rdy[k]  <= 1'b1;
          r_data[k] <= bus.late_data;
        end else begin
          r_rdy[k]  <= r_rdy[k-1];
          r_data[k] <= r_data[k-1];
        end
      end
    end else if (w_late_hit) begin
      r_rdy[LRS]  <= 1'b1;
      r_data[LRS] <= bus.late_data;
    end
  end

  // Scan youngest first and lock onto the first match, so an older ready copy
  // never masks a younger pending one.
  always_comb begin : fwd
    logic [AW-1:0] w_addr;
    logic          w_hit;
    logic          w_hrdy;
    logic [DW-1:0] w_hdata;
    w_out   = bus.rf_data;
    w_stall = 1'b0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      w_addr  = bus.rd_addr[p*AW +: AW];
      w_hit   = 1'b0;
      w_hrdy  = 1'b0;
      w_hdata = '0;
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        if (!w_hit && r_valid[k] && (r_dst[k] == w_addr)) begin
          w_hit   = 1'b1;
          w_hrdy  = r_rdy[k];
          w_hdata = r_data[k];
        end
      end
      if ((w_addr != '0) && w_hit) begin
        if (w_hrdy) begin
          w_out[p*DW +: DW] = w_hdata;
        end else begin
          w_stall = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      w_occ = w_occ + OW'(r_valid[k]);
    end
  end

  assign bus.out_data = w_out;
  assign bus.stall    = w_stall;
  assign bus.occ      = w_occ;
endmodule
